// File: rtl/vx_fpu_req_issuer_pkg.sv
// Shared widths and the fflags record for the FPU request issuer.
// These stand in for the VX_fpu_pkg / VX_fpu_define.vh definitions.
package vx_fpu_req_issuer_pkg;
  localparam int XLEN          = 32;
  localparam int INST_FPU_BITS = 4;
  localparam int INST_FMT_BITS = 2;
  localparam int INST_FRM_BITS = 3;
  localparam int FP_FLAGS_BITS = 5;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } fflags_t;
endpackage

// File: rtl/vx_fpu_req_issuer_if.sv
// Execute-side request, FPU request/response and commit channels of the issuer.
// The issuer takes the master modport; the environment takes the slave modport.
interface vx_fpu_req_issuer_if
  import vx_fpu_req_issuer_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int META_W    = 32,
  parameter int TAG_DEPTH = 4
);
  localparam int TAGW = $clog2(TAG_DEPTH);
  localparam int CNTW = $clog2(TAG_DEPTH + 1);

  logic                                 exe_valid_in, exe_ready_in;
  logic [META_W-1:0]                    exe_meta_in;
  logic [NUM_LANES-1:0]                 exe_lane_mask;
  logic [INST_FPU_BITS-1:0]             exe_op_type;
  logic [INST_FMT_BITS-1:0]             exe_fmt;
  logic [INST_FRM_BITS-1:0]             exe_frm;
  logic [NUM_LANES-1:0][XLEN-1:0]       exe_dataa, exe_datab, exe_datac;

  logic                                 fpu_valid_out, fpu_ready_out;
  logic [TAGW-1:0]                      fpu_tag_out;
  logic [INST_FPU_BITS-1:0]             fpu_op_type;
  logic [INST_FMT_BITS-1:0]             fpu_fmt;
  logic [INST_FRM_BITS-1:0]             fpu_frm;
  logic [NUM_LANES-1:0]                 fpu_lane_mask;
  logic [NUM_LANES-1:0][XLEN-1:0]       fpu_dataa, fpu_datab, fpu_datac;

  logic                                 fpu_valid_in, fpu_ready_in;
  logic [NUM_LANES-1:0][XLEN-1:0]       fpu_result;
  logic                                 fpu_has_fflags;
  fflags_t                              fpu_fflags;
  logic [TAGW-1:0]                      fpu_tag_in;

  logic                                 commit_valid, commit_ready;
  logic [META_W-1:0]                    commit_meta;
  logic [NUM_LANES-1:0]                 commit_lane_mask;
  logic [NUM_LANES-1:0][XLEN-1:0]       commit_result;
  logic                                 commit_has_fflags;
  fflags_t                              commit_fflags;

  logic [CNTW-1:0]                      pending;
  logic                                 err_tag;

  modport master (
    input  exe_valid_in, exe_meta_in, exe_lane_mask, exe_op_type, exe_fmt, exe_frm,
           exe_dataa, exe_datab, exe_datac,
           fpu_ready_out, fpu_valid_in, fpu_result, fpu_has_fflags, fpu_fflags, fpu_tag_in,
           commit_ready,
    output exe_ready_in, fpu_valid_out, fpu_tag_out, fpu_op_type, fpu_fmt, fpu_frm,
           fpu_lane_mask, fpu_dataa, fpu_datab, fpu_datac, fpu_ready_in,
           commit_valid, commit_meta, commit_lane_mask, commit_result,
           commit_has_fflags, commit_fflags, pending, err_tag
  );

  modport slave (
    output exe_valid_in, exe_meta_in, exe_lane_mask, exe_op_type, exe_fmt, exe_frm,
           exe_dataa, exe_datab, exe_datac,
           fpu_ready_out, fpu_valid_in, fpu_result, fpu_has_fflags, fpu_fflags, fpu_tag_in,
           commit_ready,
    input  exe_ready_in, fpu_valid_out, fpu_tag_out, fpu_op_type, fpu_fmt, fpu_frm,
           fpu_lane_mask, fpu_dataa, fpu_datab, fpu_datac, fpu_ready_in,
           commit_valid, commit_meta, commit_lane_mask, commit_result,
           commit_has_fflags, commit_fflags, pending, err_tag
  );
endinterface

// File: rtl/vx_fpu_tag_alloc.sv
// Tag pool: busy bitmap, lowest-free-tag encoder, full flag and outstanding count.
// Set always targets the free tag it reports; clear must name a busy tag.
module vx_fpu_tag_alloc #(
  parameter int TAG_DEPTH = 4,
  parameter int TAGW      = $clog2(TAG_DEPTH),
  parameter int CNTW      = $clog2(TAG_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set,
  input  logic                 i_clr,
  input  logic [TAGW-1:0]      i_clr_tag,
  output logic [TAG_DEPTH-1:0] o_busy,
  output logic [TAGW-1:0]      o_free_tag,
  output logic                 o_full,
  output logic [CNTW-1:0]      o_pending
);
  logic [TAG_DEPTH-1:0] r_busy;
  logic [CNTW-1:0]      r_pending;
  logic [TAGW-1:0]      w_free_tag;

  // Scan downward so the lowest clear bit is the last one written.
  always_comb begin
    w_free_tag = '0;
    for (int i = TAG_DEPTH - 1; i >= 0; i--)
      if (!r_busy[i]) w_free_tag = TAGW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      if (i_clr) r_busy[i_clr_tag]  <= 1'b0;
      if (i_set) r_busy[w_free_tag] <= 1'b1;
      case ({i_set, i_clr})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_free_tag = w_free_tag;
  assign o_full     = &r_busy;
  assign o_pending  = r_pending;
endmodule

// File: rtl/vx_fpu_req_issuer.sv
// FPU request issuer: tags outgoing requests, matches out-of-order responses
// back to their metadata and presents one registered commit record.
module vx_fpu_req_issuer
  import vx_fpu_req_issuer_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int META_W    = 32,
  parameter int TAG_DEPTH = 4,
  parameter int TAGW      = $clog2(TAG_DEPTH)
) (
  input logic                 clk,
  input logic                 reset,
  vx_fpu_req_issuer_if.master bus
);
  localparam int CNTW = $clog2(TAG_DEPTH + 1);

  logic [TAG_DEPTH-1:0] w_busy;
  logic [TAGW-1:0]      w_free_tag;
  logic                 w_full, w_acc, w_rsp_acc, w_rel;
  logic [CNTW-1:0]      w_pending;

  logic [META_W-1:0]    r_meta [TAG_DEPTH];
  logic [NUM_LANES-1:0] r_mask [TAG_DEPTH];

  logic                           r_cvalid, r_chf;
  logic [META_W-1:0]              r_cmeta;
  logic [NUM_LANES-1:0]           r_cmask;
  logic [NUM_LANES-1:0][XLEN-1:0] r_cres;
  fflags_t                        r_cff;

  vx_fpu_tag_alloc #(.TAG_DEPTH(TAG_DEPTH), .TAGW(TAGW), .CNTW(CNTW)) u_alloc (
    .clk        (clk),
    .rst        (reset),
    .i_set      (w_acc),
    .i_clr      (w_rel),
    .i_clr_tag  (bus.fpu_tag_in),
    .o_busy     (w_busy),
    .o_free_tag (w_free_tag),
    .o_full     (w_full),
    .o_pending  (w_pending)
  );

  assign bus.fpu_valid_out = bus.exe_valid_in & ~w_full;
  assign bus.exe_ready_in  = bus.fpu_ready_out & ~w_full;
  assign w_acc             = bus.exe_valid_in & bus.exe_ready_in;
  assign bus.fpu_tag_out   = w_free_tag;
  assign bus.fpu_op_type   = bus.exe_op_type;
  assign bus.fpu_fmt       = bus.exe_fmt;
  assign bus.fpu_frm       = bus.exe_frm;
  assign bus.fpu_lane_mask = bus.exe_lane_mask;
  assign bus.fpu_dataa     = bus.exe_dataa;
  assign bus.fpu_datab     = bus.exe_datab;
  assign bus.fpu_datac     = bus.exe_datac;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_meta[w_free_tag] <= bus.exe_meta_in;
      r_mask[w_free_tag] <= bus.exe_lane_mask;
    end
  end

  assign bus.fpu_ready_in = ~r_cvalid | bus.commit_ready;
  assign w_rsp_acc        = bus.fpu_valid_in & bus.fpu_ready_in;
  assign w_rel            = w_rsp_acc & w_busy[bus.fpu_tag_in];

  // A response for an idle tag is dropped; the commit slot still drains normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cvalid <= 1'b0;
      r_cmeta  <= '0;
      r_cmask  <= '0;
      r_cres   <= '0;
      r_chf    <= 1'b0;
      r_cff    <= '0;
    end else if (w_rel) begin
      r_cvalid <= 1'b1;
      r_cmeta  <= r_meta[bus.fpu_tag_in];
      r_cmask  <= r_mask[bus.fpu_tag_in];
      r_cres   <= bus.fpu_result;
      r_chf    <= bus.fpu_has_fflags;
      r_cff    <= bus.fpu_has_fflags ? bus.fpu_fflags : '0;
    end else if (bus.commit_ready) begin
      r_cvalid <= 1'b0;
    end
  end

  logic r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_err <= 1'b0;
    else if (w_rsp_acc & ~w_rel)  r_err <= 1'b1;
  end

  assign bus.commit_valid      = r_cvalid;
  assign bus.commit_meta       = r_cmeta;
  assign bus.commit_lane_mask  = r_cmask;
  assign bus.commit_result     = r_cres;
  assign bus.commit_has_fflags = r_chf;
  assign bus.commit_fflags     = r_cff;
  assign bus.pending           = w_pending;
  assign bus.err_tag           = r_err;
endmodule

// File: tb/tb_vx_fpu_req_issuer.sv
// Directed bench for vx_fpu_req_issuer with a tag-pool model checked every cycle.
module tb_vx_fpu_req_issuer;
  import vx_fpu_req_issuer_pkg::*;
  localparam int NL = 2;
  localparam int MW = 32;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_fpu_req_issuer_if #(.NUM_LANES(NL), .META_W(MW), .TAG_DEPTH(TD)) bus ();
  vx_fpu_req_issuer #(.NUM_LANES(NL), .META_W(MW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: set of busy tags with their metadata, plus the single commit slot.
  bit               m_busy [TD];
  logic [MW-1:0]    m_meta [TD];
  logic [NL-1:0]    m_mask [TD];
  bit               m_cv, m_chf, m_err;
  logic [MW-1:0]    m_cmeta;
  logic [NL-1:0]    m_cmask;
  logic [63:0]      m_cres;
  logic [4:0]       m_cff;

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < TD; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < TD; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < TD; i++) m_busy[i] = 1'b0;
    m_cv = 0; m_chf = 0; m_err = 0;
    m_cmeta = '0; m_cmask = '0; m_cres = '0; m_cff = '0;
  endtask

  task automatic m_compare();
    bit full;
    full = (m_cnt() == TD);
    chk("exe_ready_in", 64'(bus.exe_ready_in), 64'(bus.fpu_ready_out & !full));
    chk("fpu_valid_out", 64'(bus.fpu_valid_out), 64'(bus.exe_valid_in & !full));
    if (!full) chk("fpu_tag_out", 64'(bus.fpu_tag_out), 64'(m_free()));
    if (bus.exe_valid_in) begin
      chk("fwd_op", 64'(bus.fpu_op_type), 64'(bus.exe_op_type));
      chk("fwd_fmt", 64'(bus.fpu_fmt), 64'(bus.exe_fmt));
      chk("fwd_frm", 64'(bus.fpu_frm), 64'(bus.exe_frm));
      chk("fwd_mask", 64'(bus.fpu_lane_mask), 64'(bus.exe_lane_mask));
      chk("fwd_a", 64'(bus.fpu_dataa), 64'(bus.exe_dataa));
      chk("fwd_b", 64'(bus.fpu_datab), 64'(bus.exe_datab));
      chk("fwd_c", 64'(bus.fpu_datac), 64'(bus.exe_datac));
    end
    chk("fpu_ready_in", 64'(bus.fpu_ready_in), 64'(!m_cv | bus.commit_ready));
    chk("commit_valid", 64'(bus.commit_valid), 64'(m_cv));
    if (m_cv) begin
      chk("commit_meta", 64'(bus.commit_meta), 64'(m_cmeta));
      chk("commit_mask", 64'(bus.commit_lane_mask), 64'(m_cmask));
      chk("commit_result", 64'(bus.commit_result), m_cres);
      chk("commit_hf", 64'(bus.commit_has_fflags), 64'(m_chf));
      chk("commit_ff", 64'(bus.commit_fflags), 64'(m_cff));
    end
    chk("pending", 64'(bus.pending), 64'(m_cnt()));
    chk("err_tag", 64'(bus.err_tag), 64'(m_err));
  endtask

  task automatic m_step();
    bit full, acc, racc;
    int fr, t;
    full = (m_cnt() == TD);
    fr   = m_free();
    acc  = bus.exe_valid_in & bus.fpu_ready_out & !full;
    racc = bus.fpu_valid_in & (!m_cv | bus.commit_ready);
    t    = int'(bus.fpu_tag_in);
    if (racc && m_busy[t]) begin
      m_cv = 1; m_cmeta = m_meta[t]; m_cmask = m_mask[t];
      m_cres = 64'(bus.fpu_result); m_chf = bus.fpu_has_fflags;
      m_cff = bus.fpu_has_fflags ? 5'(bus.fpu_fflags) : 5'd0;
      m_busy[t] = 0;
    end else begin
      if (racc) m_err = 1;
      if (bus.commit_ready) m_cv = 0;
    end
    if (acc) begin
      m_busy[fr] = 1; m_meta[fr] = bus.exe_meta_in; m_mask[fr] = bus.exe_lane_mask;
    end
  endtask

  initial m_reset();

  always begin
    @(negedge clk);
    #2;
    if (reset) m_reset();
    m_compare();
    if (!reset) m_step();
  end

  task automatic req(input logic [31:0] meta, input logic [NL-1:0] mask, input int k);
    bus.exe_valid_in  = 1'b1;
    bus.exe_meta_in   = meta;
    bus.exe_lane_mask = mask;
    bus.exe_op_type   = 4'(k + 3);
    bus.exe_fmt       = 2'(k);
    bus.exe_frm       = 3'(k + 1);
    bus.exe_dataa     = {32'(k + 32'h1100), 32'(k + 32'h1000)};
    bus.exe_datab     = {32'(k + 32'h2200), 32'(k + 32'h2000)};
    bus.exe_datac     = {32'(k + 32'h3300), 32'(k + 32'h3000)};
  endtask

  task automatic rsp(input int tag, input logic hf, input logic [4:0] ff);
    bus.fpu_valid_in   = 1'b1;
    bus.fpu_tag_in     = 2'(tag);
    bus.fpu_result     = {32'(32'hF0F0_0000 + tag), 32'(32'h0BAD_0000 + tag)};
    bus.fpu_has_fflags = hf;
    bus.fpu_fflags     = ff;
  endtask

  int ord [4] = '{2, 0, 3, 1};
  logic [NL-1:0] mk [4] = '{2'd1, 2'd2, 2'd3, 2'd1};

  initial begin
    reset = 1'b1;
    bus.exe_valid_in = 0; bus.exe_meta_in = '0; bus.exe_lane_mask = '0;
    bus.exe_op_type = '0; bus.exe_fmt = '0; bus.exe_frm = '0;
    bus.exe_dataa = '0; bus.exe_datab = '0; bus.exe_datac = '0;
    bus.fpu_ready_out = 1; bus.fpu_valid_in = 0; bus.fpu_result = '0;
    bus.fpu_has_fflags = 0; bus.fpu_fflags = '0; bus.fpu_tag_in = '0;
    bus.commit_ready = 1;

    @(negedge clk); @(negedge clk); #1;
    chk("rst_cv", 64'(bus.commit_valid), 64'd0);
    chk("rst_pend", 64'(bus.pending), 64'd0);
    chk("rst_err", 64'(bus.err_tag), 64'd0);
    chk("rst_tag", 64'(bus.fpu_tag_out), 64'd0);
    chk("rst_frdy", 64'(bus.fpu_ready_in), 64'd1);
    chk("rst_cmeta", 64'(bus.commit_meta), 64'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req(32'hA000_0000 + i, mk[i], i); #1;
      chk("alloc_tag", 64'(bus.fpu_tag_out), 64'(i));
      chk("alloc_rdy", 64'(bus.exe_ready_in), 64'd1);
    end
    @(negedge clk); req(32'hA000_0004, 2'd3, 4); #1;
    chk("full_rdy", 64'(bus.exe_ready_in), 64'd0);
    chk("full_vld", 64'(bus.fpu_valid_out), 64'd0);
    chk("full_pend", 64'(bus.pending), 64'd4);

    @(negedge clk); bus.exe_valid_in = 0; rsp(ord[0], 1, 5'(1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) rsp(ord[k], 1, 5'(k + 1)); else bus.fpu_valid_in = 0;
      #1;
      chk("ooo_cv", 64'(bus.commit_valid), 64'd1);
      chk("ooo_meta", 64'(bus.commit_meta), 64'(32'hA000_0000 + ord[k-1]));
      chk("ooo_mask", 64'(bus.commit_lane_mask), 64'(mk[ord[k-1]]));
    end
    @(negedge clk); #1;
    chk("drain_pend", 64'(bus.pending), 64'd0);
    chk("drain_cv", 64'(bus.commit_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req(32'hB000_0000 + i, mk[i], i + 8); #1;
      chk("refill_tag", 64'(bus.fpu_tag_out), 64'(i));
    end
    @(negedge clk); req(32'hC000_0001, 2'd2, 12); rsp(1, 1, 5'd0); #1;
    chk("stall_rdy", 64'(bus.exe_ready_in), 64'd0);
    @(negedge clk); bus.fpu_valid_in = 0; #1;
    chk("reuse_tag", 64'(bus.fpu_tag_out), 64'd1);
    chk("reuse_rdy", 64'(bus.exe_ready_in), 64'd1);
    chk("reuse_cmeta", 64'(bus.commit_meta), 64'hB000_0001);

    @(negedge clk); bus.exe_valid_in = 0; bus.commit_ready = 0; rsp(0, 1, 5'h04);
    @(negedge clk); rsp(2, 1, 5'h02); #1;
    chk("bp_cv", 64'(bus.commit_valid), 64'd1);
    chk("bp_meta", 64'(bus.commit_meta), 64'hB000_0000);
    chk("bp_frdy", 64'(bus.fpu_ready_in), 64'd0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("bp_hold", 64'(bus.commit_meta), 64'hB000_0000);
      chk("bp_frdy_hold", 64'(bus.fpu_ready_in), 64'd0);
    end
    @(negedge clk); bus.commit_ready = 1; #1;
    chk("bp_release", 64'(bus.fpu_ready_in), 64'd1);
    @(negedge clk); rsp(3, 1, 5'h01); #1;
    chk("bp_next", 64'(bus.commit_meta), 64'hB000_0002);
    @(negedge clk); rsp(1, 0, 5'h1F); #1;
    chk("bp_next3", 64'(bus.commit_meta), 64'hB000_0003);
    @(negedge clk); bus.fpu_valid_in = 0; #1;
    chk("nff_meta", 64'(bus.commit_meta), 64'hC000_0001);
    chk("nff_hf", 64'(bus.commit_has_fflags), 64'd0);
    chk("nff_ff", 64'(bus.commit_fflags), 64'd0);
    @(negedge clk); #1;
    chk("bp_pend", 64'(bus.pending), 64'd0);

    @(negedge clk); req(32'hD000_0000, 2'd3, 20); #1;
    chk("err_alloc", 64'(bus.fpu_tag_out), 64'd0);
    @(negedge clk); bus.exe_valid_in = 0; rsp(3, 1, 5'h1F);
    @(negedge clk); bus.fpu_valid_in = 0; #1;
    chk("err_set", 64'(bus.err_tag), 64'd1);
    chk("err_nocommit", 64'(bus.commit_valid), 64'd0);
    chk("err_pend", 64'(bus.pending), 64'd1);
    repeat (2) @(negedge clk);
    #1 chk("err_sticky", 64'(bus.err_tag), 64'd1);

    @(negedge clk); bus.commit_ready = 0; rsp(0, 1, 5'h08);
    @(negedge clk); bus.fpu_valid_in = 0; #1;
    chk("pre_rst_cv", 64'(bus.commit_valid), 64'd1);
    chk("pre_rst_meta", 64'(bus.commit_meta), 64'hD000_0000);

    @(negedge clk); #3 reset = 1'b1; #1;
    chk("arst_cv", 64'(bus.commit_valid), 64'd0);
    chk("arst_pend", 64'(bus.pending), 64'd0);
    chk("arst_err", 64'(bus.err_tag), 64'd0);
    chk("arst_tag", 64'(bus.fpu_tag_out), 64'd0);
    chk("arst_frdy", 64'(bus.fpu_ready_in), 64'd1);
    chk("arst_meta", 64'(bus.commit_meta), 64'd0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0; bus.commit_ready = 1;
    repeat (3) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
